// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial add/subtract controller: steps a WIDTH-bit operation through an
// external 4-bit adder one nibble per cycle, least significant nibble first.
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [3:0]       adder_a_o,
  output logic [3:0]       adder_b_o,
  output logic             adder_carry_o,
  input  logic [3:0]       adder_res_i,
  input  logic             adder_carry_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] res_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic             busy_o
);
  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [N-1:0][3:0]   a_q, b_q, res_q;
  logic [IW-1:0]       idx_q;
  logic                carry_q, carry_out_q, ovf_q;
  logic                last;

  assign last       = (idx_q == IW'(N - 1));
  assign res_o      = res_q;
  assign carry_o    = carry_out_q;
  assign overflow_o = ovf_q;

  always_comb begin
    state_d       = state_q;
    req_ready_o   = 1'b0;
    res_valid_o   = 1'b0;
    busy_o        = 1'b1;
    adder_a_o     = 4'h0;
    adder_b_o     = 4'h0;
    adder_carry_o = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (req_valid_i) state_d = RUN;
      end
      RUN: begin
        adder_a_o     = a_q[idx_q];
        adder_b_o     = b_q[idx_q];
        adder_carry_o = carry_q;
        if (last) state_d = DONE;
      end
      DONE: begin
        res_valid_o = 1'b1;
        if (res_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (req_valid_i) begin
          a_q     <= a_i;
          b_q     <= b_i ^ {WIDTH{sub_i}};
          carry_q <= sub_i;
          idx_q   <= '0;
        end
        RUN: begin
          res_q[idx_q] <= adder_res_i;
          carry_q      <= adder_carry_i;
          // Flags are taken from the top nibble's adder return on the final edge.
          if (last) begin
            carry_out_q <= adder_carry_i;
            ovf_q       <= (a_q[N-1][3] == b_q[N-1][3]) && (adder_res_i[3] != a_q[N-1][3]);
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench for nibble_serial_add_ctrl with a ripple 4-bit adder model.
module tb_nibble_serial_add_ctrl;
  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i, req_valid_i, req_ready_o, sub_i;
  logic [31:0] a_i, b_i, res_o;
  logic [3:0]  adder_a_o, adder_b_o, adder_res_i;
  logic        adder_carry_o, adder_carry_i;
  logic        res_valid_o, res_ready_i, carry_o, overflow_o, busy_o;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  assign {adder_carry_i, adder_res_i} = {1'b0, adder_a_o} + {1'b0, adder_b_o} + {4'h0, adder_carry_o};

  nibble_serial_add_ctrl #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .a_i(a_i), .b_i(b_i), .sub_i(sub_i),
    .adder_a_o(adder_a_o), .adder_b_o(adder_b_o), .adder_carry_o(adder_carry_o),
    .adder_res_i(adder_res_i), .adder_carry_i(adder_carry_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_o(res_o),
    .carry_o(carry_o), .overflow_o(overflow_o), .busy_o(busy_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every accepted result against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst_i && res_valid_o && res_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got res %h with empty scoreboard, expected no result", res_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("res", res_o, e.res);
        check("carry", {31'b0, carry_o}, {31'b0, e.c});
        check("overflow", {31'b0, overflow_o}, {31'b0, e.v});
      end
    end
  end

  // Called just after a rising edge with the DUT in IDLE; returns in the DONE cycle.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] er, input logic ec, input logic ev);
    logic [31:0] bx;
    bx = b ^ {32{s}};
    exp_q.push_back('{er, ec, ev});
    check("req_ready_idle", {31'b0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1; a_i = a; b_i = b; sub_i = s;
    @(posedge clk); #1;
    req_valid_i = 1'b0; a_i = $urandom; b_i = $urandom; sub_i = ~s;
    check("adder_a_nib0", {28'b0, adder_a_o}, {28'b0, a[3:0]});
    check("adder_b_nib0", {28'b0, adder_b_o}, {28'b0, bx[3:0]});
    check("adder_cin0", {31'b0, adder_carry_o}, {31'b0, s});
    repeat (7) @(posedge clk);
    #1;
    check("valid_low_last_run", {31'b0, res_valid_o}, 32'd0);
    check("busy_run", {31'b0, busy_o}, 32'd1);
    @(posedge clk); #1;
    check("valid_latency", {31'b0, res_valid_o}, 32'd1);
  endtask

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; res_ready_i = 1'b1;
    a_i = '0; b_i = '0; sub_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_valid", {31'b0, res_valid_o}, 32'd0);
    check("rst_res", res_o, 32'd0);
    check("rst_flags", {30'b0, carry_o, overflow_o}, 32'd0);
    check("rst_adder", {23'b0, adder_a_o, adder_b_o, adder_carry_o}, 32'd0);
    rst_i = 1'b0;
    @(posedge clk); #1;

    do_op(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("idle_retain_res", res_o, 32'h0000_0008);
    check("idle_adder_zero", {23'b0, adder_a_o, adder_b_o, adder_carry_o}, 32'd0);
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    @(posedge clk); #1;
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    @(posedge clk); #1;
    do_op(32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    @(posedge clk); #1;
    do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    @(posedge clk); #1;

    // Consumer stalls in DONE while stray requests arrive.
    res_ready_i = 1'b0;
    do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      req_valid_i = 1'b1;
      @(posedge clk); #1;
      check("hold_valid", {31'b0, res_valid_o}, 32'd1);
      check("hold_res", res_o, 32'h2345_6789);
      check("hold_no_ready", {31'b0, req_ready_o}, 32'd0);
    end
    req_valid_i = 1'b0; res_ready_i = 1'b1;
    @(posedge clk); #1;
    check("ready_after_accept", {31'b0, req_ready_o}, 32'd1);

    // Reset in the 4th RUN cycle discards the operation.
    req_valid_i = 1'b1; a_i = 32'h0101_0101; b_i = 32'h0202_0202; sub_i = 1'b0;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    check("mid_rst_busy", {31'b0, busy_o}, 32'd0);
    check("mid_rst_res", res_o, 32'd0);
    check("mid_rst_ready", {31'b0, req_ready_o}, 32'd1);
    repeat (10) @(posedge clk);
    #1;
    check("mid_rst_no_valid", {31'b0, res_valid_o}, 32'd0);
    do_op(32'h0000_000A, 32'h0000_0006, 1'b0, 32'h0000_0010, 1'b0, 1'b0);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
